// File: rtl/counter_mod_falling.sv
// counter_mod_falling: falling-edge modulo-N up/down counter with load, wrap/saturate and terminal-count pulse.
// Define COUNTER_PRESCALE_EN to compile in a PRESCALE-edge prescaler ahead of each count step.
module counter_mod_falling #(
    parameter int WIDTH    = 6,
    parameter int MODULUS  = 64,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             sat,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             at_limit
);
    localparam logic [WIDTH-1:0] top = WIDTH'(MODULUS - 1);
    logic             step;
    logic             tc_nx;
    logic [WIDTH-1:0] out_nx;
`ifdef COUNTER_PRESCALE_EN
    localparam int pw = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [pw-1:0] pcnt;
    assign step = en && pcnt == pw'(PRESCALE - 1);
    always_ff @(negedge clk or negedge rst) begin
        if (!rst)
            pcnt <= '0;
        else if (load)
            pcnt <= '0;
        else if (en)
            pcnt <= step ? '0 : pcnt + 1'b1;
    end
`else
    assign step = en && PRESCALE > 0;
`endif
    assign at_limit = out == (up ? top : '0);
    always_comb begin
        tc_nx  = !load && step && at_limit && !sat;
        out_nx = load ? (load_val > top ? top : load_val)
               : !step ? out
               : at_limit ? (sat ? out : (up ? '0 : top))
               : (up ? out + 1'b1 : out - 1'b1);
    end
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            out <= '0;
            tc  <= 1'b0;
        end else begin
            out <= out_nx;
            tc  <= tc_nx;
        end
    end
endmodule

// File: tb/tb_counter_mod_falling.sv
// tb_counter_mod_falling: directed checks of counter_mod_falling at several WIDTH/MODULUS points.
module tb_counter_mod_falling;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic       sat = 1'b0;
    logic [5:0] lv = '0;
    logic [5:0] a_out;
    logic [3:0] b_out;
    logic [0:0] c_out;
    logic       a_tc, a_al, b_tc, b_al, c_tc, c_al;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    counter_mod_falling #(.WIDTH(6), .MODULUS(64)) dut_a (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv),
        .sat(sat), .out(a_out), .tc(a_tc), .at_limit(a_al));
    counter_mod_falling #(.WIDTH(4), .MODULUS(10)) dut_b (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
        .sat(sat), .out(b_out), .tc(b_tc), .at_limit(b_al));
    counter_mod_falling #(.WIDTH(1), .MODULUS(2)) dut_c (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[0:0]),
        .sat(sat), .out(c_out), .tc(c_tc), .at_limit(c_al));
`ifdef COUNTER_PRESCALE_EN
    logic [3:0] d_out;
    logic       d_tc, d_al;
    counter_mod_falling #(.WIDTH(4), .MODULUS(10), .PRESCALE(3)) dut_d (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(lv[3:0]),
        .sat(sat), .out(d_out), .tc(d_tc), .at_limit(d_al));
`endif

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        en = 0; load = 0; up = 1; sat = 0;
        rst = 1'b0;
        #2;
        checks += 3;
        if (a_out !== 6'd0) begin errors++; $display("FAIL reset_out got=%0d want=0", a_out); end
        if (a_tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b want=0", a_tc); end
        if (a_al !== 1'b0) begin errors++; $display("FAIL reset_al_up got=%b want=0", a_al); end
        up = 0;
        #1;
        checks += 2;
        if (a_al !== 1'b1) begin errors++; $display("FAIL reset_al_down got=%b want=1", a_al); end
        if (b_al !== 1'b1) begin errors++; $display("FAIL reset_b_al_down got=%b want=1", b_al); end
        up = 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        checks++;
        if (a_out !== 6'd0) begin errors++; $display("FAIL reset_hold got=%0d want=0", a_out); end
    endtask

    task automatic test_wrap_up;
        do_reset();
        en = 1; up = 1; sat = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            checks += 2;
            if (a_out !== 6'(i % 64)) begin errors++; $display("FAIL wrap_out edge=%0d got=%0d want=%0d", i, a_out, i % 64); end
            if (a_tc !== (i == 64)) begin errors++; $display("FAIL wrap_tc edge=%0d got=%b want=%b", i, a_tc, i == 64); end
            if (i == 63) begin
                checks++;
                if (a_al !== 1'b1) begin errors++; $display("FAIL wrap_al got=%b want=1", a_al); end
            end
        end
        en = 0;
        tick();
        checks++;
        if (a_tc !== 1'b0) begin errors++; $display("FAIL wrap_tc_clear got=%b want=0", a_tc); end
    endtask

    task automatic test_load_clamp;
        en = 0; up = 1; sat = 0; load = 1; lv = 6'd12;
        tick();
        load = 0;
        checks += 3;
        if (b_out !== 4'd9) begin errors++; $display("FAIL clamp_out got=%0d want=9", b_out); end
        if (b_tc !== 1'b0) begin errors++; $display("FAIL clamp_tc got=%b want=0", b_tc); end
        if (b_al !== 1'b1) begin errors++; $display("FAIL clamp_al got=%b want=1", b_al); end
        en = 1;
        tick();
        checks += 2;
        if (b_out !== 4'd0) begin errors++; $display("FAIL clamp_wrap_out got=%0d want=0", b_out); end
        if (b_tc !== 1'b1) begin errors++; $display("FAIL clamp_wrap_tc got=%b want=1", b_tc); end
        tick();
        checks += 2;
        if (b_out !== 4'd1) begin errors++; $display("FAIL clamp_next_out got=%0d want=1", b_out); end
        if (b_tc !== 1'b0) begin errors++; $display("FAIL clamp_next_tc got=%b want=0", b_tc); end
        en = 0;
    endtask

    task automatic test_sat_down;
        logic [3:0] exp [4] = '{4'd1, 4'd0, 4'd0, 4'd0};
        load = 1; lv = 6'd2;
        tick();
        load = 0; up = 0; sat = 1; en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks += 3;
            if (b_out !== exp[i]) begin errors++; $display("FAIL sat_out edge=%0d got=%0d want=%0d", i, b_out, exp[i]); end
            if (b_tc !== 1'b0) begin errors++; $display("FAIL sat_tc edge=%0d got=%b want=0", i, b_tc); end
            if (b_al !== (i >= 1)) begin errors++; $display("FAIL sat_al edge=%0d got=%b want=%b", i, b_al, i >= 1); end
        end
        sat = 0;
        tick();
        checks += 2;
        if (b_out !== 4'd9) begin errors++; $display("FAIL down_wrap_out got=%0d want=9", b_out); end
        if (b_tc !== 1'b1) begin errors++; $display("FAIL down_wrap_tc got=%b want=1", b_tc); end
        en = 0;
        tick();
        checks += 2;
        if (b_out !== 4'd9) begin errors++; $display("FAIL hold_out got=%0d want=9", b_out); end
        if (b_tc !== 1'b0) begin errors++; $display("FAIL hold_tc got=%b want=0", b_tc); end
        up = 1;
    endtask

    task automatic test_load_priority;
        en = 1; up = 1; sat = 0; load = 1; lv = 6'd5;
        tick();
        load = 0;
        checks += 3;
        if (a_out !== 6'd5) begin errors++; $display("FAIL prio_out got=%0d want=5", a_out); end
        if (a_tc !== 1'b0) begin errors++; $display("FAIL prio_tc got=%b want=0", a_tc); end
        if (b_out !== 4'd5) begin errors++; $display("FAIL prio_b_out got=%0d want=5", b_out); end
        tick();
        checks++;
        if (a_out !== 6'd6) begin errors++; $display("FAIL prio_step got=%0d want=6", a_out); end
        en = 0;
    endtask

    task automatic test_async_reset;
        en = 0; load = 1; lv = 6'd8;
        tick();
        load = 0; en = 1; up = 0; sat = 0;
        tick();
        checks += 2;
        if (a_out !== 6'd7) begin errors++; $display("FAIL arst_pre_out got=%0d want=7", a_out); end
        if (c_tc !== 1'b1) begin errors++; $display("FAIL arst_pre_tc got=%b want=1", c_tc); end
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks += 4;
        if (a_out !== 6'd0) begin errors++; $display("FAIL arst_out got=%0d want=0", a_out); end
        if (a_tc !== 1'b0) begin errors++; $display("FAIL arst_tc got=%b want=0", a_tc); end
        if (c_out !== 1'b0) begin errors++; $display("FAIL arst_c_out got=%0d want=0", c_out); end
        if (c_tc !== 1'b0) begin errors++; $display("FAIL arst_c_tc got=%b want=0", c_tc); end
        en = 0; up = 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_back_to_back;
        do_reset();
        en = 1; sat = 0;
        for (int i = 0; i < 6; i++) begin
            up = (i % 2 == 1);
            tick();
            checks += 2;
            if (c_tc !== 1'b1) begin errors++; $display("FAIL b2b_tc edge=%0d got=%b want=1", i, c_tc); end
            if (c_out !== 1'(i % 2 == 0)) begin errors++; $display("FAIL b2b_out edge=%0d got=%0d want=%0d", i, c_out, i % 2 == 0); end
        end
        up = 1;
        tick();
        checks += 3;
        if (c_out !== 1'b1) begin errors++; $display("FAIL up2_out got=%0d want=1", c_out); end
        if (c_tc !== 1'b0) begin errors++; $display("FAIL up2_tc got=%b want=0", c_tc); end
        if (c_al !== 1'b1) begin errors++; $display("FAIL up2_al got=%b want=1", c_al); end
        tick();
        checks += 2;
        if (c_out !== 1'b0) begin errors++; $display("FAIL up2_wrap_out got=%0d want=0", c_out); end
        if (c_tc !== 1'b1) begin errors++; $display("FAIL up2_wrap_tc got=%b want=1", c_tc); end
        en = 0;
    endtask

`ifdef COUNTER_PRESCALE_EN
    task automatic test_prescale;
        logic [3:0] exp [3] = '{4'd4, 4'd4, 4'd5};
        do_reset();
        en = 1; up = 1; sat = 0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (d_out !== 4'(i / 3)) begin errors++; $display("FAIL pre_out edge=%0d got=%0d want=%0d", i, d_out, i / 3); end
        end
        tick();
        tick();
        checks++;
        if (d_out !== 4'd3) begin errors++; $display("FAIL pre_hold got=%0d want=3", d_out); end
        load = 1; lv = 6'd4;
        tick();
        load = 0;
        checks += 2;
        if (d_out !== 4'd4) begin errors++; $display("FAIL pre_load got=%0d want=4", d_out); end
        if (d_tc !== 1'b0) begin errors++; $display("FAIL pre_load_tc got=%b want=0", d_tc); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (d_out !== exp[i]) begin errors++; $display("FAIL pre_after_load edge=%0d got=%0d want=%0d", i, d_out, exp[i]); end
        end
        en = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_wrap_up();
        test_load_clamp();
        test_sat_down();
        test_load_priority();
        test_async_reset();
        test_back_to_back();
`ifdef COUNTER_PRESCALE_EN
        test_prescale();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/counter_mod_falling.md
# counter_mod_falling

Parametrised modulo-N up/down counter, clocked on the falling edge of `clk`, replacing the fixed 6-bit ripple counter in the processor's timing and step-generation paths. It adds a configurable width and modulus, a direction input, a synchronous parallel load, a wrap/saturate mode and a registered terminal-count pulse. An optional prescaler can be compiled in. All state is synchronous to one clock edge, so there are no ripple-clock chains.

## Interface
- `WIDTH`, default 6: counter width in bits.
- `MODULUS`, default 64: count range is 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- `PRESCALE`, default 1: number of enabled edges per count step. Used only when `COUNTER_PRESCALE_EN` is defined. Legal range is PRESCALE ≥ 1.
- `clk` in 1: clock. All state updates on its falling edge.
- `rst` in 1: reset, asynchronous, active-low.
- `en` in 1: count enable, sampled on the falling edge.
- `up` in 1: direction. 1 counts up, 0 counts down.
- `load` in 1: synchronous parallel load.
- `load_val` in WIDTH: value applied on load.
- `sat` in 1: end-of-range mode. 1 saturates, 0 wraps.
- `out` out WIDTH: current count, registered.
- `tc` out 1: registered terminal-count pulse. High for one clock period on a wrap.
- `at_limit` out 1: combinational. High when `out` equals the end value for the current direction (MODULUS-1 when up, 0 when down).

## Operation
- Reset (`rst`=0): `out`=0, `tc`=0 and the prescaler count is 0, immediately and asynchronously. `at_limit` follows `out` (it is 1 if `up`=0).
- Priority on each falling edge: reset, then `load`, then counting step, then hold.
- Load:
  - `out` ← `load_val`, clamped to MODULUS-1 when `load_val` ≥ MODULUS.
  - `tc` ← 0 and the prescaler is cleared.
  - `en` is ignored on that edge.
- Step (`en`=1, no load, prescaler terminal reached):
  - Up, `out` < MODULUS-1: `out`+1, `tc` ← 0.
  - Up, `out` = MODULUS-1: if `sat`=0, `out` ← 0 and `tc` ← 1. If `sat`=1, hold and `tc` ← 0.
  - Down, `out` > 0: `out`-1, `tc` ← 0.
  - Down, `out` = 0: if `sat`=0, `out` ← MODULUS-1 and `tc` ← 1. If `sat`=1, hold and `tc` ← 0.
- No step: `out` holds and `tc` ← 0.
- Arithmetic:
  - Compares and increments are done at WIDTH bits and never overflow WIDTH.
  - When MODULUS = 2^WIDTH, the wrap equals natural roll-over, but `tc` is still generated by the explicit compare.
- Changing `up` or `sat` takes effect on the next falling edge. There is no internal history of direction.

## Timing
- Latency: `out` and `tc` update at the falling edge on which the controlling inputs are sampled. They are stable until the next falling edge.
- Inputs (`en`, `up`, `load`, `load_val`, `sat`) must meet setup/hold around the falling edge of `clk`.
- `tc` is high for exactly one clock period (falling edge to falling edge) per wrap event. Back-to-back wraps (MODULUS=2, continuous `en`) hold `tc` high continuously.
- Reset assertion mid-count clears all state without waiting for a clock. After `rst` rises, the first falling edge with `en`=1 performs a step (or a prescaler advance).
- `rst` deassertion is assumed synchronised upstream to the rising edge, away from the active falling edge.

## Configuration
- `COUNTER_PRESCALE_EN` defined:
  - An internal prescaler of $clog2(PRESCALE) bits (min 1) counts enabled edges.
  - A step occurs only on an enabled edge where the prescaler equals PRESCALE-1; the prescaler then returns to 0.
  - The prescaler clears on reset and on `load`. With `en`=0 it holds.
  - PRESCALE=1 behaves identically to the undefined case.
- `COUNTER_PRESCALE_EN` undefined: no prescaler logic exists. Every enabled edge is a step and `PRESCALE` is ignored.

## Test plan
- WIDTH=6, MODULUS=64, `up`=1, `sat`=0, `en`=1 for 64 falling edges from reset → `out` 0..63 then 0. `tc`=1 only for the period after the 63→0 edge.
- WIDTH=4, MODULUS=10, `load_val`=12 with `load`=1 → `out`=9, `tc`=0. One enabled up step → `out`=0, `tc`=1.
- MODULUS=10, `up`=0, `sat`=1, starting at 2, 4 enabled edges → `out` 1, 0, 0, 0. `tc` never 1. `at_limit`=1 from `out`=0 onward.
- `load`=1 and `en`=1 on the same edge with `load_val`=5 → `out`=5, no step. `rst` pulled low mid-edge-period at `out`=7 → `out`=0 and `tc`=0 before the next edge.
- With `COUNTER_PRESCALE_EN`, PRESCALE=3, `en`=1 continuous → `out` increments on every 3rd falling edge. `load` at prescaler count 2 → next step occurs 3 enabled edges after the load.
